// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS countdown with a one-second prescaler.
// Counts down with borrow and pulses done when it reaches 00:00.
module countdown_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PW       = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] digits,
    output logic        running,
    output logic        expired,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_t;

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic [15:0]   dec_val;
    logic [15:0]   sat_val;
    logic          tick;
    logic          go;
    logic          halt;

    function automatic logic [3:0] clamp(
        input logic [3:0] v,
        input logic [3:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

    assign sat_val = {
        clamp(load_value[15:12], 4'd9),
        clamp(load_value[11:8],  4'd9),
        clamp(load_value[7:4],   4'd5),
        clamp(load_value[3:0],   4'd9)
    };

    assign tick = (presc == TICK_LAST);
    assign go   = start & ~stop;
    assign halt = stop & ~start;

    // Borrow ripples from seconds-ones up through minutes-tens.
    always_comb begin
        dec_val = digits;
        if (digits[3:0] != 4'd0) begin
            dec_val[3:0] = digits[3:0] - 4'd1;
        end else begin
            dec_val[3:0] = 4'd9;
            if (digits[7:4] != 4'd0) begin
                dec_val[7:4] = digits[7:4] - 4'd1;
            end else begin
                dec_val[7:4] = 4'd5;
                if (digits[11:8] != 4'd0) begin
                    dec_val[11:8] = digits[11:8] - 4'd1;
                end else begin
                    dec_val[11:8]  = 4'd9;
                    dec_val[15:12] = digits[15:12] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            presc   <= '0;
            digits  <= 16'h0000;
            running <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state   <= IDLE;
                presc   <= '0;
                digits  <= sat_val;
                running <= 1'b0;
                expired <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, PAUSE: begin
                        if (go && digits != 16'h0000) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        presc <= tick ? '0 : presc + PW'(1);
                        if (tick) begin
                            digits <= dec_val;
                        end
                        // Expiry beats a stop arriving on the same edge.
                        if (tick && dec_val == 16'h0000) begin
                            state   <= EXPIRED;
                            running <= 1'b0;
                            expired <= 1'b1;
                            done    <= 1'b1;
                        end else if (halt) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                    EXPIRED: begin
                        digits <= 16'h0000;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: randomized and directed checks of countdown_timer
// against a remaining-seconds reference model.
module tb_countdown_timer;

    localparam int TD = 4;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        stop;
    logic [15:0] digits;
    logic        running;
    logic        expired;
    logic        done;

    int checks;
    int failures;

    int m_secs;
    int m_phase;
    int m_mode;
    bit m_done;

    countdown_timer #(.TICK_DIV(TD), .PW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .digits     (digits),
        .running    (running),
        .expired    (expired),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [15:0] obs,
        input logic [15:0] exp
    );
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int to_secs(input logic [15:0] v);
        int mt, mo, st, so;
        mt = min_i(int'(v[15:12]), 9);
        mo = min_i(int'(v[11:8]), 9);
        st = min_i(int'(v[7:4]), 5);
        so = min_i(int'(v[3:0]), 9);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m, r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    // mode: 0 idle, 1 run, 2 pause, 3 expired
    task automatic model(
        input logic        r,
        input logic        l,
        input logic [15:0] lv,
        input logic        st,
        input logic        sp
    );
        m_done = 1'b0;
        if (!r) begin
            m_secs  = 0;
            m_phase = 0;
            m_mode  = 0;
        end else if (l) begin
            m_secs  = to_secs(lv);
            m_phase = 0;
            m_mode  = 0;
        end else if (m_mode == 1) begin
            m_phase++;
            if (m_phase == TD) begin
                m_phase = 0;
                m_secs--;
                if (m_secs == 0) begin
                    m_mode = 3;
                    m_done = 1'b1;
                end
            end
            if (m_mode == 1 && sp && !st) m_mode = 2;
        end else if ((m_mode == 0 || m_mode == 2) && st && !sp && m_secs != 0) begin
            m_mode = 1;
        end
    endtask

    task automatic cyc(
        input logic        r,
        input logic        l,
        input logic [15:0] lv,
        input logic        st,
        input logic        sp
    );
        reset      = r;
        load       = l;
        load_value = lv;
        start      = st;
        stop       = sp;
        @(posedge clk);
        model(r, l, lv, st, sp);
        #1;
        chk("digits",  digits,  to_bcd(m_secs));
        chk("running", {15'd0, running}, {15'd0, m_mode == 1});
        chk("expired", {15'd0, expired}, {15'd0, m_mode == 3});
        chk("done",    {15'd0, done},    {15'd0, m_done});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 16'h0, 0, 0);
    endtask

    task automatic ld(input logic [15:0] v);
        cyc(1, 1, v, 0, 0);
    endtask

    task automatic go();
        cyc(1, 0, 16'h0, 1, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_secs   = 0;
        m_phase  = 0;
        m_mode   = 0;
        m_done   = 0;

        cyc(0, 0, 16'h0, 0, 0);
        chk("rst_digits", digits, 16'h0000);

        ld(16'h1234); go(); idle(3);
        cyc(0, 0, 16'h0, 0, 0);
        chk("t1_digits", digits, 16'h0000);
        chk("t1_run", {15'd0, running}, 16'h0);
        go();
        chk("t1_start_ign", {15'd0, running}, 16'h0);

        ld(16'h1000); go(); idle(4);
        chk("t2_borrow", digits, 16'h0959);
        chk("t2_run", {15'd0, running}, 16'h1);
        idle(4);
        chk("t2_next", digits, 16'h0958);

        ld(16'h0001); go(); idle(4);
        chk("t3_done", {15'd0, done}, 16'h1);
        chk("t3_zero", digits, 16'h0000);
        idle(1);
        chk("t3_once", {15'd0, done}, 16'h0);
        go();
        chk("t3_stay", {15'd0, expired}, 16'h1);
        ld(16'h0005);
        chk("t3_clear", {15'd0, expired}, 16'h0);

        ld(16'h0010); go(); idle(1);
        cyc(1, 0, 16'h0, 0, 1);
        idle(20);
        chk("t4_hold", digits, 16'h0010);
        go(); idle(1);
        chk("t4_early", digits, 16'h0010);
        idle(1);
        chk("t4_resume", digits, 16'h0009);

        ld(16'hFA7C);
        chk("t5_sat", digits, 16'h9959);
        cyc(1, 1, 16'h0100, 1, 0);
        chk("t5_prio", {15'd0, running}, 16'h0);
        go();
        cyc(1, 0, 16'h0, 1, 1);
        chk("t5_both", {15'd0, running}, 16'h1);

        ld(16'h0230); go(); idle(3);
        ld(16'h0230);
        chk("t6_load", digits, 16'h0230);
        go(); idle(3);
        chk("t6_wait", digits, 16'h0230);
        idle(1);
        chk("t6_dec", digits, 16'h0229);

        for (int i = 0; i < 4000; i++) begin
            logic        r, l, st, sp;
            logic [15:0] lv;
            r  = ($urandom_range(0, 99) != 0);
            l  = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 1) == 0)
                lv = 16'($urandom_range(0, 16'h0019));
            else
                lv = 16'($urandom);
            cyc(r, l, lv, st, sp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Four-digit BCD minutes:seconds countdown timer (MM:SS, 00:00 to 99:59).
- The digit chain counts down with borrow, the complement of the team's mod-M up counters.
- An internal prescaler turns clk into one-second decrements.
- Feeds the seven-segment display mux; done drives the buzzer/LED logic.

Parameters:
TICK_DIV, 50_000_000, clk cycles per one-second decrement (benches use 4)
PW, 26, prescaler width; must satisfy 2^PW >= TICK_DIV

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low; reset==0 at a rising clk edge clears all state
load  input  1  one-cycle strobe; capture load_value
load_value  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}
start  input  1  one-cycle strobe; begin or resume countdown
stop  input  1  one-cycle strobe; pause countdown
digits  output  16  current BCD value, same nibble order as load_value
running  output  1  1 while in RUN
expired  output  1  1 while in EXPIRED
done  output  1  one-cycle pulse on reaching 00:00

Behaviour:
- All outputs are registered.
- Reset (reset==0 at an edge): digits=16'h0000, prescaler=0, state=IDLE, running=0, expired=0, done=0. Reset overrides every other input, in any state, including mid-countdown.
- States and outputs:
  - IDLE: running=0, expired=0
  - RUN: running=1
  - PAUSE: running=0
  - EXPIRED: expired=1, digits=0000
- Input priority: reset > load > start/stop.
- load, in any state: digits<=load_value, prescaler<=0, state<=IDLE, expired<=0.
  - Illegal digits saturate on capture: any nibble >9 becomes 9; sec_tens >5 becomes 5.
  - Example: 16'hFA7C stores as 16'h9959.
- start:
  - IDLE or PAUSE with digits!=0000 -> RUN.
  - IDLE with digits==0000 -> ignored.
  - Ignored in RUN and EXPIRED.
- stop: RUN -> PAUSE; ignored elsewhere.
- start and stop in the same cycle: both ignored.
- Prescaler:
  - RUN: counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and a decrement fires.
  - PAUSE: holds its value, so partial seconds are kept across pause/resume.
  - Cleared by load and reset.
- First decrement occurs TICK_DIV rising edges after the edge that sampled start (fresh prescaler).
- Decrement borrow chain, evaluated in a single cycle:
  - sec_ones: 0->9 with borrow, else -1
  - sec_tens: on borrow, 0->5 with borrow, else -1
  - min_ones: on borrow, 0->9 with borrow, else -1
  - min_tens: on borrow, -1
  - Never underflows, because RUN is left at 0000.
- Expiry: when a decrement produces 0000, on that same edge:
  - digits=0000
  - state<=EXPIRED, running=0, expired=1
  - done=1 for exactly one cycle
- EXPIRED is left only by load or reset; start is ignored.
- done never re-asserts without a new load+start.
- load on the same edge as an expiring decrement: load wins; no done, state IDLE.

Test Plan (TICK_DIV=4):
1. Reset: hold reset=0 for 1 edge during RUN at 12:34 -> next cycle digits=16'h0000, running=0, expired=0, done=0; start is then ignored.
2. Borrow chain: load 16'h1000, start -> 4 edges later digits=16'h0959, running=1; 4 more edges -> 16'h0958.
3. Expiry: load 16'h0001, start -> on 4th edge digits=0000, done=1 for one cycle only, expired=1, running=0; a following start leaves the state unchanged; load 16'h0005 clears expired.
4. Pause/resume: load 16'h0010, start, stop after 2 edges, idle 20 cycles -> digits hold 0010; start -> decrement to 16'h0009 exactly 2 edges later.
5. Saturation and priority: load 16'hFA7C -> digits=16'h9959. load asserted with start in the same cycle -> state IDLE. start+stop together in RUN -> stays RUN.
6. Load mid-run: load 16'h0230 during RUN with prescaler=3 -> digits=16'h0230, IDLE, no decrement; start -> first decrement 4 edges later to 16'h0229.
